// File: rtl/clause_eval_pkg.sv
// Shared definitions for the clause batch driver: default sizing, FSM state
// encodings, and the literal padding constants used to fill incomplete batches.
package clause_eval_pkg;

    localparam int unsigned DEF_CLUSTER_SIZE = 20;
    localparam int unsigned DEF_NSAT         = 3;
    localparam int unsigned DEF_REDUCE       = 1;
    localparam int unsigned K                = DEF_NSAT - DEF_REDUCE;
    localparam int unsigned DEF_NUM_VARS     = 256;
    localparam int unsigned DEF_EVAL_LAT     = 1;
    localparam int unsigned DEF_CNT_W        = 16;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_ACC   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;

    // One literal as seen by the evaluator: variable value and negation flag
    typedef struct packed {
        logic val;
        logic neg;
    } lit_t;

    // Padding literals: TRUE keeps an empty clause satisfied, FALSE leaves a
    // partial clause decided only by the literals it really has.
    localparam lit_t LIT_TRUE  = '{val: 1'b1, neg: 1'b0};
    localparam lit_t LIT_FALSE = '{val: 1'b0, neg: 1'b0};

    function automatic int unsigned lits_per_clause(input int unsigned nsat,
                                                    input int unsigned reduce);
        return nsat - reduce;
    endfunction

endpackage

// File: rtl/clause_batch_driver_if.sv
// Literal stream + evaluator cluster bus of the clause batch driver.
//   lit_valid/lit_ready/lit_var/lit_neg/lit_last : occurrence-list literal stream
//   var_val/var_neg                               : per-slot literal drive to the cluster (slot c*LITS+k)
//   brk                                           : per-clause break bits from the cluster
// master = driver side, slot = reader/cluster side.
interface clause_batch_driver_if #(
    parameter int unsigned CLUSTER_SIZE = clause_eval_pkg::DEF_CLUSTER_SIZE,
    parameter int unsigned LITS         = clause_eval_pkg::K,
    parameter int unsigned VAR_W        = 8
);
    logic                         lit_valid;
    logic                         lit_ready;
    logic [VAR_W-1:0]             lit_var;
    logic                         lit_neg;
    logic                         lit_last;
    logic [LITS*CLUSTER_SIZE-1:0] var_val;
    logic [LITS*CLUSTER_SIZE-1:0] var_neg;
    logic [CLUSTER_SIZE-1:0]      brk;

    modport master (
        input  lit_valid, lit_var, lit_neg, lit_last, brk,
        output lit_ready, var_val, var_neg
    );

    modport slave (
        output lit_valid, lit_var, lit_neg, lit_last, brk,
        input  lit_ready, var_val, var_neg
    );
endinterface

// File: rtl/break_popcount.sv
// Combinational population count of the cluster break vector.
//   bits_i       : N break bits
//   popcnt_c_o   : number of set bits (combinational)
module break_popcount #(
    parameter int unsigned N     = 20,
    parameter int unsigned OUT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     bits_i,
    output logic [OUT_W-1:0] popcnt_c_o
);

    always_comb begin
        popcnt_c_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            popcnt_c_o = popcnt_c_o + OUT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/clause_batch_driver.sv
// Clause batch driver: packs a streamed literal list into batches of
// CLUSTER_SIZE clauses, looks each literal up in the current assignment,
// drives the evaluator cluster and accumulates the returned break count.
// Ports:
//   clk_i, reset_ni      : clock, asynchronous active-low reset
//   start_i              : begin a new evaluation (IDLE only)
//   assign_i             : current assignment, stable while busy_o
//   bus (master)         : literal stream in, var_val/var_neg out, brk in
//   busy_o, done_o       : status; done_o pulses once when break_cnt_o is final
//   break_cnt_o          : saturating break count
// Optional feature macro BREAK_THRESH_EN adds thresh_i/aborted_o: once the
// count reaches thresh_i after a non-final batch the rest of the list is
// drained unevaluated and the run ends with aborted_o set.
module clause_batch_driver
    import clause_eval_pkg::*;
#(
    parameter int unsigned CLUSTER_SIZE = DEF_CLUSTER_SIZE,
    parameter int unsigned NSAT         = DEF_NSAT,
    parameter int unsigned REDUCE       = DEF_REDUCE,
    parameter int unsigned NUM_VARS     = DEF_NUM_VARS,
    parameter int unsigned VAR_W        = $clog2(NUM_VARS),
    parameter int unsigned EVAL_LAT     = DEF_EVAL_LAT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    input  logic [NUM_VARS-1:0]      assign_i,
    clause_batch_driver_if.master    bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [CNT_W-1:0]         break_cnt_o
`ifdef BREAK_THRESH_EN
    ,
    input  logic [CNT_W-1:0]         thresh_i,
    output logic                     aborted_o
`endif
);

    localparam int unsigned LITS  = lits_per_clause(NSAT, REDUCE);
    localparam int unsigned SLOTS = LITS * CLUSTER_SIZE;
    localparam int unsigned CW    = $clog2(CLUSTER_SIZE + 1);
    localparam int unsigned KW    = (LITS > 1) ? $clog2(LITS) : 1;
    localparam int unsigned SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned PW    = $clog2(CLUSTER_SIZE + 1);
    localparam int unsigned WW    = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic             last_q, last_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [SLOTS-1:0] stg_val_q, stg_val_d;
    logic [SLOTS-1:0] stg_neg_q, stg_neg_d;
    logic [SLOTS-1:0] val_q, val_d;
    logic [SLOTS-1:0] neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
`ifdef BREAK_THRESH_EN
    logic             aborted_q, aborted_d;
`endif

    logic [VAR_W-1:0] lit_var;
    logic             accept;
    logic [SW-1:0]    slot;
    logic [PW-1:0]    pop;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_sat;
    logic [SLOTS-1:0] pad_val, pad_neg;

    assign lit_var = bus.lit_var;
    assign accept  = bus.lit_valid & ready_q;
    assign slot    = SW'(c_q) * SW'(LITS) + SW'(k_q);

    break_popcount #(
        .N     (CLUSTER_SIZE),
        .OUT_W (PW)
    ) u_popcount (
        .bits_i     (bus.brk),
        .popcnt_c_o (pop)
    );

    // Saturating accumulate of this batch's breaks
    assign cnt_sum = SUM_W'(cnt_q) + SUM_W'(pop);
    assign cnt_sat = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    // Batch image with padding; (c_q,k_q) is the first slot never written
    always_comb begin
        pad_val = '0;
        pad_neg = '0;
        for (int cc = 0; cc < int'(CLUSTER_SIZE); cc++) begin
            for (int kk = 0; kk < int'(LITS); kk++) begin
                if ((CW'(cc) < c_q) || ((CW'(cc) == c_q) && (KW'(kk) < k_q))) begin
                    pad_val[cc*LITS+kk] = stg_val_q[cc*LITS+kk];
                    pad_neg[cc*LITS+kk] = stg_neg_q[cc*LITS+kk];
                end else if ((CW'(cc) == c_q) && (k_q != '0)) begin
                    pad_val[cc*LITS+kk] = LIT_FALSE.val;
                    pad_neg[cc*LITS+kk] = LIT_FALSE.neg;
                end else begin
                    pad_val[cc*LITS+kk] = LIT_TRUE.val;
                    pad_neg[cc*LITS+kk] = LIT_TRUE.neg;
                end
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        k_d       = k_q;
        last_d    = last_q;
        wait_d    = wait_q;
        stg_val_d = stg_val_q;
        stg_neg_d = stg_neg_q;
        val_d     = val_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
`ifdef BREAK_THRESH_EN
        aborted_d = aborted_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    c_d     = '0;
                    k_d     = '0;
`ifdef BREAK_THRESH_EN
                    aborted_d = 1'b0;
`endif
                end
            end
            ST_FILL: begin
                if (accept) begin
                    stg_val_d[slot] = assign_i[lit_var];
                    stg_neg_d[slot] = bus.lit_neg;
                    if (k_q == KW'(LITS - 1)) begin
                        k_d = '0;
                        c_d = c_q + CW'(1);
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                    if (bus.lit_last ||
                        ((c_q == CW'(CLUSTER_SIZE - 1)) && (k_q == KW'(LITS - 1)))) begin
                        state_d = ST_ISSUE;
                        last_d  = bus.lit_last;
                    end
                end
            end
            ST_ISSUE: begin
                val_d   = pad_val;
                neg_d   = pad_neg;
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WW'(EVAL_LAT - 1)) begin
                    state_d = ST_ACC;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_ACC: begin
                cnt_d   = cnt_sat;
                state_d = ST_FILL;
                c_d     = '0;
                k_d     = '0;
                if (last_q) begin
                    state_d = ST_DONE;
                end
`ifdef BREAK_THRESH_EN
                else if (cnt_sat >= thresh_i) begin
                    state_d = ST_DRAIN;
                end
`endif
            end
`ifdef BREAK_THRESH_EN
            ST_DRAIN: begin
                if (accept && bus.lit_last) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
`ifdef BREAK_THRESH_EN
        ready_d = (state_d == ST_FILL) || (state_d == ST_DRAIN);
`else
        ready_d = (state_d == ST_FILL);
`endif
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            k_q       <= '0;
            last_q    <= 1'b0;
            wait_q    <= '0;
            stg_val_q <= '0;
            stg_neg_q <= '0;
            val_q     <= '0;
            neg_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef BREAK_THRESH_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            k_q       <= k_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            stg_val_q <= stg_val_d;
            stg_neg_q <= stg_neg_d;
            val_q     <= val_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef BREAK_THRESH_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign bus.lit_ready = ready_q;
    assign bus.var_val   = val_q;
    assign bus.var_neg   = neg_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign break_cnt_o   = cnt_q;
`ifdef BREAK_THRESH_EN
    assign aborted_o     = aborted_q;
`endif

endmodule

// File: tb/tb_clause_batch_driver.sv
// Directed bench for clause_batch_driver with a registered evaluator cluster
// model (EVAL_LAT = 1). Assignment: var3 = var5 = 1, all other vars 0.
// False clause = (var3,neg1)(var0,neg0); true clauses alternate between
// (var0,neg0)(var5,neg0) and (var6,neg1)(var0,neg0).
module tb_clause_batch_driver;
    import clause_eval_pkg::*;

    localparam int unsigned CS    = 20;
    localparam int unsigned LITS  = 2;
    localparam int unsigned NV    = 256;
    localparam int unsigned VW    = 8;
    localparam int unsigned CNT_W = 16;
    localparam int          MAXL  = 100;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             start_i;
    logic [NV-1:0]    assign_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] break_cnt_o;
`ifdef BREAK_THRESH_EN
    logic [CNT_W-1:0] thresh_i;
    logic             aborted_o;
`endif

    int checks = 0;
    int errors = 0;
    int closes = 0;
    logic ready_prev = 1'b0;

    logic [VW-1:0] lv [MAXL];
    logic          ln [MAXL];
    int            n_lits;

    clause_batch_driver_if #(.CLUSTER_SIZE(CS), .LITS(LITS), .VAR_W(VW)) bus ();

    clause_batch_driver #(
        .CLUSTER_SIZE (CS),
        .NSAT         (3),
        .REDUCE       (1),
        .NUM_VARS     (NV),
        .VAR_W        (VW),
        .EVAL_LAT     (1),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .start_i     (start_i),
        .assign_i    (assign_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .break_cnt_o (break_cnt_o)
`ifdef BREAK_THRESH_EN
        ,
        .thresh_i    (thresh_i),
        .aborted_o   (aborted_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Registered cluster: a clause breaks when every literal it receives is false
    function automatic logic [CS-1:0] cluster_eval(input logic [CS*LITS-1:0] v,
                                                   input logic [CS*LITS-1:0] n);
        logic [CS-1:0] b;
        logic          any;
        for (int c = 0; c < int'(CS); c++) begin
            any = 1'b0;
            for (int k = 0; k < int'(LITS); k++) any = any | (v[c*LITS+k] ^ n[c*LITS+k]);
            b[c] = ~any;
        end
        return b;
    endfunction

    always @(posedge clk_i) bus.brk <= cluster_eval(bus.var_val, bus.var_neg);

    // Each falling edge of lit_ready is one closed batch
    always @(negedge clk_i) begin
        if (ready_prev && !bus.lit_ready) closes = closes + 1;
        ready_prev = bus.lit_ready;
    end

    task automatic add_lit(input int v, input bit n);
        lv[n_lits] = VW'(v);
        ln[n_lits] = n;
        n_lits++;
    endtask

    task automatic build_list(input int nclauses, input logic [63:0] fmask);
        n_lits = 0;
        for (int c = 0; c < nclauses; c++) begin
            if (fmask[c]) begin
                add_lit(3, 1'b1); add_lit(0, 1'b0);
            end else if (c % 2 == 0) begin
                add_lit(0, 1'b0); add_lit(5, 1'b0);
            end else begin
                add_lit(6, 1'b1); add_lit(0, 1'b0);
            end
        end
    endtask

    // Streams literals 0..upto-1; returns on the negedge after the final acceptance
    task automatic send(input int upto, input bit gaps, input bit poke, output bit ok);
        int  idx;
        int  budget;
        bit  v;
        idx    = 0;
        budget = 0;
        ok     = 1'b1;
        while (idx < upto) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (poke && ($urandom_range(0, 3) == 0)) start_i = 1'b1;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.lit_valid = v;
            bus.lit_var   = lv[idx];
            bus.lit_neg   = ln[idx];
            bus.lit_last  = (idx == n_lits - 1);
            if (v && bus.lit_ready) idx++;
            budget++;
            if (budget > 2000) begin
                ok = 1'b0;
                break;
            end
        end
        @(negedge clk_i);
        bus.lit_valid = 1'b0;
        bus.lit_last  = 1'b0;
        start_i       = 1'b0;
    endtask

    // Start, stream the whole list, then count negedges until done_o
    task automatic run(input bit gaps, input bit poke, output bit ok, output int lat);
        @(negedge clk_i);
        start_i = 1'b1;
        send(n_lits, gaps, poke, ok);
        lat = 0;
        while (done_o !== 1'b1 && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (break_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", break_cnt_o); end
        checks++; if (bus.lit_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.lit_ready); end
        checks++; if (bus.var_val !== '0) begin errors++; $display("FAIL reset_var_val: got %h expected 0", bus.var_val); end
        checks++; if (bus.var_neg !== '0) begin errors++; $display("FAIL reset_var_neg: got %h expected 0", bus.var_neg); end
`ifdef BREAK_THRESH_EN
        checks++; if (aborted_o !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b expected 0", aborted_o); end
`endif
        reset_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_full_batch();
        bit ok;
        int lat;
        int base;
        build_list(20, (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 19));
        base = closes;
        run(1'b0, 1'b0, ok, lat);
        checks++; if (!ok || done_o !== 1'b1) begin errors++; $display("FAIL full_done: done_o=%b send_ok=%0d expected done_o=1", done_o, ok); end
        checks++; if (lat != 3) begin errors++; $display("FAIL full_latency: got %0d cycles expected 3", lat); end
        checks++; if (break_cnt_o !== 16'd3) begin errors++; $display("FAIL full_cnt: got %0d expected 3", break_cnt_o); end
        checks++; if (closes - base != 1) begin errors++; $display("FAIL full_batches: got %0d expected 1", closes - base); end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL full_pulse: done_o=%b busy_o=%b expected 0/0", done_o, busy_o); end
    endtask

    task automatic test_partial_clauses();
        bit ok;
        int lat;
        build_list(7, (64'd1 << 2) | (64'd1 << 6));
        run(1'b0, 1'b0, ok, lat);
        checks++; if (!ok || done_o !== 1'b1) begin errors++; $display("FAIL part7_done: done_o=%b expected 1", done_o); end
        checks++; if (break_cnt_o !== 16'd2) begin errors++; $display("FAIL part7_cnt: got %0d expected 2", break_cnt_o); end
        checks++; if (bus.var_val[39:14] !== {26{1'b1}}) begin errors++; $display("FAIL part7_pad_val: got %h expected 3ffffff", bus.var_val[39:14]); end
        checks++; if (bus.var_neg[39:14] !== '0) begin errors++; $display("FAIL part7_pad_neg: got %h expected 0", bus.var_neg[39:14]); end
        // Half-filled clause 4 holding one false literal must still break
        build_list(4, 64'd1);
        add_lit(0, 1'b0);
        run(1'b0, 1'b0, ok, lat);
        checks++; if (!ok || done_o !== 1'b1) begin errors++; $display("FAIL half_done: done_o=%b expected 1", done_o); end
        checks++; if (break_cnt_o !== 16'd2) begin errors++; $display("FAIL half_cnt: got %0d expected 2", break_cnt_o); end
        checks++; if (bus.var_val[39:8] !== {30'h3fffffff, 2'b00}) begin errors++; $display("FAIL half_pad_val: got %h expected fffffffc", bus.var_val[39:8]); end
        checks++; if (bus.var_neg[39:8] !== '0) begin errors++; $display("FAIL half_pad_neg: got %h expected 0", bus.var_neg[39:8]); end
    endtask

    task automatic test_multi_batch();
        bit ok;
        int lat;
        int base;
        build_list(45, (64'd1 << 1) | (64'd1 << 19) | (64'd1 << 20) | (64'd1 << 33) | (64'd1 << 44));
        base = closes;
        run(1'b0, 1'b0, ok, lat);
        checks++; if (!ok || done_o !== 1'b1) begin errors++; $display("FAIL multi_done: done_o=%b expected 1", done_o); end
        checks++; if (closes - base != 3) begin errors++; $display("FAIL multi_batches: got %0d expected 3", closes - base); end
        checks++; if (break_cnt_o !== 16'd5) begin errors++; $display("FAIL multi_cnt: got %0d expected 5", break_cnt_o); end
        checks++; if (lat != 3) begin errors++; $display("FAIL multi_latency: got %0d expected 3", lat); end
        checks++; if (bus.var_val[39:10] !== {30{1'b1}} || bus.var_neg[39:10] !== '0) begin
            errors++; $display("FAIL multi_pad: val=%h neg=%h expected 3fffffff/0", bus.var_val[39:10], bus.var_neg[39:10]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        build_list(20, (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 19));
        run(1'b1, 1'b1, ok, lat);
        checks++; if (!ok || done_o !== 1'b1) begin errors++; $display("FAIL gaps20_done: done_o=%b expected 1", done_o); end
        checks++; if (break_cnt_o !== 16'd3) begin errors++; $display("FAIL gaps20_cnt: got %0d expected 3", break_cnt_o); end
        repeat (3) @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || break_cnt_o !== 16'd3) begin
            errors++; $display("FAIL gaps20_hold: busy_o=%b cnt=%0d expected 0/3", busy_o, break_cnt_o); end
        build_list(45, (64'd1 << 1) | (64'd1 << 19) | (64'd1 << 20) | (64'd1 << 33) | (64'd1 << 44));
        run(1'b1, 1'b1, ok, lat);
        checks++; if (!ok || done_o !== 1'b1) begin errors++; $display("FAIL gaps45_done: done_o=%b expected 1", done_o); end
        checks++; if (break_cnt_o !== 16'd5) begin errors++; $display("FAIL gaps45_cnt: got %0d expected 5", break_cnt_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        build_list(45, (64'd1 << 1) | (64'd1 << 19) | (64'd1 << 20) | (64'd1 << 33) | (64'd1 << 44));
        @(negedge clk_i);
        start_i = 1'b1;
        send(50, 1'b0, 1'b0, ok);
        checks++; if (!ok || break_cnt_o !== 16'd2 || bus.lit_ready !== 1'b1) begin
            errors++; $display("FAIL mid_pre: cnt=%0d ready=%b expected 2/1", break_cnt_o, bus.lit_ready); end
        reset_ni = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || bus.lit_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_status: busy=%b done=%b ready=%b expected 0/0/0", busy_o, done_o, bus.lit_ready); end
        checks++; if (break_cnt_o !== '0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", break_cnt_o); end
        checks++; if (bus.var_val !== '0 || bus.var_neg !== '0) begin
            errors++; $display("FAIL mid_rst_vars: val=%h neg=%h expected 0/0", bus.var_val, bus.var_neg); end
        @(negedge clk_i);
        reset_ni = 1'b1;
        build_list(20, (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 19));
        run(1'b0, 1'b0, ok, lat);
        checks++; if (!ok || done_o !== 1'b1) begin errors++; $display("FAIL mid_rerun_done: done_o=%b expected 1", done_o); end
        checks++; if (break_cnt_o !== 16'd3) begin errors++; $display("FAIL mid_rerun_cnt: got %0d expected 3", break_cnt_o); end
    endtask

`ifdef BREAK_THRESH_EN
    task automatic test_threshold();
        bit ok;
        int lat;
        thresh_i = 16'd2;
        build_list(45, (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 19) | (64'd1 << 25));
        run(1'b0, 1'b0, ok, lat);
        checks++; if (!ok || done_o !== 1'b1) begin errors++; $display("FAIL thr_done: done_o=%b send_ok=%0d expected 1", done_o, ok); end
        checks++; if (aborted_o !== 1'b1) begin errors++; $display("FAIL thr_aborted: got %b expected 1", aborted_o); end
        checks++; if (break_cnt_o !== 16'd3) begin errors++; $display("FAIL thr_cnt: got %0d expected 3", break_cnt_o); end
        thresh_i = '1;
        build_list(20, (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 19));
        run(1'b0, 1'b0, ok, lat);
        checks++; if (aborted_o !== 1'b0 || break_cnt_o !== 16'd3) begin
            errors++; $display("FAIL thr_clear: aborted=%b cnt=%0d expected 0/3", aborted_o, break_cnt_o); end
    endtask
`endif

    initial begin
        reset_ni      = 1'b0;
        start_i       = 1'b0;
        assign_i      = '0;
        assign_i[3]   = 1'b1;
        assign_i[5]   = 1'b1;
        bus.lit_valid = 1'b0;
        bus.lit_var   = '0;
        bus.lit_neg   = 1'b0;
        bus.lit_last  = 1'b0;
        n_lits        = 0;
`ifdef BREAK_THRESH_EN
        thresh_i      = '1;
`endif
        test_reset();
        test_full_batch();
        test_partial_clauses();
        test_multi_batch();
        test_back_to_back();
        test_reset_mid();
`ifdef BREAK_THRESH_EN
        test_threshold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
